// File: rtl/hazard_ctrl.sv
// Hazard controller for a five-stage pipeline. It keeps a shadow copy of the destination
// and timing fields for E/M/W and derives the stall, forwarding selects and a stall counter.
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        d_valid_i,
    input  logic [4:0]  d_rs_i,
    input  logic [4:0]  d_rt_i,
    input  logic [1:0]  d_tuse_rs_i,
    input  logic [1:0]  d_tuse_rt_i,
    input  logic [4:0]  d_dst_i,
    input  logic [1:0]  d_tnew_i,
    output logic        stall_o,
    output logic [1:0]  fwd_d_rs_o,
    output logic [1:0]  fwd_d_rt_o,
    output logic [1:0]  fwd_e_rs_o,
    output logic [1:0]  fwd_e_rt_o,
    output logic [15:0] stall_cnt_o
);

    localparam logic [1:0] SelGrf = 2'b00;
    localparam logic [1:0] SelE   = 2'b01;
    localparam logic [1:0] SelM   = 2'b10;
    localparam logic [1:0] SelW   = 2'b11;

    logic [4:0]  eRs_q, eRs_d;
    logic [4:0]  eRt_q, eRt_d;
    logic [4:0]  eDst_q, eDst_d;
    logic [1:0]  eTnew_q, eTnew_d;
    logic [4:0]  mDst_q, mDst_d;
    logic [1:0]  mTnew_q, mTnew_d;
    logic [4:0]  wDst_q, wDst_d;
    logic [15:0] stallCnt_q, stallCnt_d;

    logic hazRsE, hazRsM, hazRtE, hazRtM;
    logic stall;

    // A source collides with a stage when it names that stage's nonzero destination.
    function automatic logic srcMatch(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    // A tuse of 3 can never be below a tnew of at most 2, but it is excluded explicitly.
    function automatic logic hazard(input logic       valid,
                                    input logic [4:0] src,
                                    input logic [1:0] tuse,
                                    input logic [4:0] dst,
                                    input logic [1:0] tnew);
        return valid && srcMatch(src, dst) && (tuse != 2'd3) && (tuse < tnew);
    endfunction

    // The nearest matching stage decides; a match that is not yet ready blocks older stages.
    function automatic logic [1:0] fwdDSel(input logic [4:0] src,
                                           input logic [4:0] eDst,
                                           input logic [1:0] eTnew,
                                           input logic [4:0] mDst,
                                           input logic [1:0] mTnew,
                                           input logic [4:0] wDst);
        logic [1:0] sel;
        sel = SelGrf;
        if (srcMatch(src, eDst)) begin
            sel = (eTnew == 2'd0) ? SelE : SelGrf;
        end else if (srcMatch(src, mDst)) begin
            sel = (mTnew == 2'd0) ? SelM : SelGrf;
        end else if (srcMatch(src, wDst)) begin
            sel = SelW;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwdESel(input logic [4:0] src,
                                           input logic [4:0] mDst,
                                           input logic [1:0] mTnew,
                                           input logic [4:0] wDst);
        logic [1:0] sel;
        sel = SelGrf;
        if (srcMatch(src, mDst)) begin
            sel = (mTnew == 2'd0) ? SelM : SelGrf;
        end else if (srcMatch(src, wDst)) begin
            sel = SelW;
        end
        return sel;
    endfunction

    always_comb begin
        hazRsE = hazard(d_valid_i, d_rs_i, d_tuse_rs_i, eDst_q, eTnew_q);
        hazRsM = hazard(d_valid_i, d_rs_i, d_tuse_rs_i, mDst_q, mTnew_q);
        hazRtE = hazard(d_valid_i, d_rt_i, d_tuse_rt_i, eDst_q, eTnew_q);
        hazRtM = hazard(d_valid_i, d_rt_i, d_tuse_rt_i, mDst_q, mTnew_q);
        stall  = hazRsE | hazRsM | hazRtE | hazRtM;
    end

    always_comb begin
        fwd_d_rs_o = fwdDSel(d_rs_i, eDst_q, eTnew_q, mDst_q, mTnew_q, wDst_q);
        fwd_d_rt_o = fwdDSel(d_rt_i, eDst_q, eTnew_q, mDst_q, mTnew_q, wDst_q);
        fwd_e_rs_o = fwdESel(eRs_q, mDst_q, mTnew_q, wDst_q);
        fwd_e_rt_o = fwdESel(eRt_q, mDst_q, mTnew_q, wDst_q);
    end

    // A stalled D instruction stays put, so E receives a bubble while M and W still advance.
    always_comb begin
        eRs_d   = 5'd0;
        eRt_d   = 5'd0;
        eDst_d  = 5'd0;
        eTnew_d = 2'd0;
        if (!stall && d_valid_i) begin
            eRs_d   = d_rs_i;
            eRt_d   = d_rt_i;
            eDst_d  = d_dst_i;
            eTnew_d = d_tnew_i;
        end
        mDst_d  = eDst_q;
        mTnew_d = (eTnew_q == 2'd0) ? 2'd0 : eTnew_q - 2'd1;
        wDst_d  = mDst_q;

        stallCnt_d = stallCnt_q;
        if (stall && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            eRs_q      <= 5'd0;
            eRt_q      <= 5'd0;
            eDst_q     <= 5'd0;
            eTnew_q    <= 2'd0;
            mDst_q     <= 5'd0;
            mTnew_q    <= 2'd0;
            wDst_q     <= 5'd0;
            stallCnt_q <= 16'd0;
        end else begin
            eRs_q      <= eRs_d;
            eRt_q      <= eRt_d;
            eDst_q     <= eDst_d;
            eTnew_q    <= eTnew_d;
            mDst_q     <= mDst_d;
            mTnew_q    <= mTnew_d;
            wDst_q     <= wDst_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_o     = stall;
    assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: short instruction sequences with hand-computed
// stall, forwarding and stall-counter expectations, plus a long saturation run.
module tb_hazard_ctrl;

    logic        clk_i;
    logic        reset_i;
    logic        d_valid_i;
    logic [4:0]  d_rs_i;
    logic [4:0]  d_rt_i;
    logic [1:0]  d_tuse_rs_i;
    logic [1:0]  d_tuse_rt_i;
    logic [4:0]  d_dst_i;
    logic [1:0]  d_tnew_i;
    logic        stall_o;
    logic [1:0]  fwd_d_rs_o;
    logic [1:0]  fwd_d_rt_o;
    logic [1:0]  fwd_e_rs_o;
    logic [1:0]  fwd_e_rt_o;
    logic [15:0] stall_cnt_o;

    int checkCount;
    int errorCount;

    hazard_ctrl dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .d_valid_i   (d_valid_i),
        .d_rs_i      (d_rs_i),
        .d_rt_i      (d_rt_i),
        .d_tuse_rs_i (d_tuse_rs_i),
        .d_tuse_rt_i (d_tuse_rt_i),
        .d_dst_i     (d_dst_i),
        .d_tnew_i    (d_tnew_i),
        .stall_o     (stall_o),
        .fwd_d_rs_o  (fwd_d_rs_o),
        .fwd_d_rt_o  (fwd_d_rt_o),
        .fwd_e_rs_o  (fwd_e_rs_o),
        .fwd_e_rt_o  (fwd_e_rt_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic applyStimulus(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [1:0] tuseRs, input logic [1:0] tuseRt,
                                 input logic [4:0] dst, input logic [1:0] tnew);
        d_valid_i   = valid;
        d_rs_i      = rs;
        d_rt_i      = rt;
        d_tuse_rs_i = tuseRs;
        d_tuse_rt_i = tuseRt;
        d_dst_i     = dst;
        d_tnew_i    = tnew;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyBubble();
        applyStimulus(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
    endtask

    task automatic doReset();
        reset_i = 1'b0;
        applyBubble();
        tick();
        tick();
        reset_i = 1'b1;
        #1;
    endtask

    task automatic checkAllFwdZero(input string tag);
        checkOutput({tag, "_fdrs"}, {14'd0, fwd_d_rs_o}, 16'd0);
        checkOutput({tag, "_fdrt"}, {14'd0, fwd_d_rt_o}, 16'd0);
        checkOutput({tag, "_fers"}, {14'd0, fwd_e_rs_o}, 16'd0);
        checkOutput({tag, "_fert"}, {14'd0, fwd_e_rt_o}, 16'd0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset_i    = 1'b0;
        applyBubble();

        // Reset state
        doReset();
        checkOutput("rst_stall", {15'd0, stall_o}, 16'd0);
        checkOutput("rst_cnt", stall_cnt_o, 16'd0);
        checkAllFwdZero("rst");

        // lw $1 then addu $1,$3: one stall cycle, then W forwarding into E
        applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2);
        checkOutput("lw_stall", {15'd0, stall_o}, 16'd0);
        tick();
        applyStimulus(1'b1, 5'd1, 5'd3, 2'd1, 2'd1, 5'd4, 2'd1);
        checkOutput("lwuse_stall", {15'd0, stall_o}, 16'd1);
        checkOutput("lwuse_fdrs", {14'd0, fwd_d_rs_o}, 16'd0);
        tick();
        checkOutput("lwuse_release", {15'd0, stall_o}, 16'd0);
        checkOutput("lwuse_cnt", stall_cnt_o, 16'd1);
        checkOutput("lwuse_fdrs_blocked", {14'd0, fwd_d_rs_o}, 16'd0);
        tick();
        applyBubble();
        checkOutput("lwuse_fers", {14'd0, fwd_e_rs_o}, 16'd3);
        checkOutput("lwuse_fert", {14'd0, fwd_e_rt_o}, 16'd0);
        checkOutput("lwuse_cnt2", stall_cnt_o, 16'd1);

        // addu $2 then beq $2: one stall, then M forwarding into D
        doReset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1);
        tick();
        applyStimulus(1'b1, 5'd2, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
        checkOutput("beq_stall", {15'd0, stall_o}, 16'd1);
        tick();
        checkOutput("beq_release", {15'd0, stall_o}, 16'd0);
        checkOutput("beq_fdrs", {14'd0, fwd_d_rs_o}, 16'd2);
        checkOutput("beq_cnt", stall_cnt_o, 16'd1);

        // jal then jr $31: forwarded from E, then M, then W as it ages
        doReset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd31, 5'd31, 2'd0, 2'd0, 5'd0, 2'd0);
        checkOutput("jr_stall", {15'd0, stall_o}, 16'd0);
        checkOutput("jr_fdrs_e", {14'd0, fwd_d_rs_o}, 16'd1);
        checkOutput("jr_fdrt_e", {14'd0, fwd_d_rt_o}, 16'd1);
        tick();
        checkOutput("jr_fdrs_m", {14'd0, fwd_d_rs_o}, 16'd2);
        tick();
        checkOutput("jr_fdrs_w", {14'd0, fwd_d_rs_o}, 16'd3);

        // jal then an ALU reader of $31: M forwarding into E
        doReset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd31, 5'd0, 2'd1, 2'd3, 5'd5, 2'd1);
        checkOutput("jalalu_stall", {15'd0, stall_o}, 16'd0);
        tick();
        applyBubble();
        checkOutput("jalalu_fers", {14'd0, fwd_e_rs_o}, 16'd2);

        // Register 0 never stalls or forwards
        doReset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2);
        tick();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 5'd6, 2'd1);
        checkOutput("r0_stall", {15'd0, stall_o}, 16'd0);
        checkAllFwdZero("r0_d");
        tick();
        applyBubble();
        checkAllFwdZero("r0_e");

        // tuse 3 is never a hazard
        doReset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2);
        tick();
        applyStimulus(1'b1, 5'd1, 5'd1, 2'd3, 2'd3, 5'd0, 2'd0);
        checkOutput("tuse3_stall", {15'd0, stall_o}, 16'd0);

        // Reset during the lw/use stall drops the pending hazard
        doReset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2);
        tick();
        applyStimulus(1'b1, 5'd1, 5'd3, 2'd1, 2'd1, 5'd4, 2'd1);
        checkOutput("rstmid_stall_pre", {15'd0, stall_o}, 16'd1);
        reset_i = 1'b0;
        tick();
        checkOutput("rstmid_stall", {15'd0, stall_o}, 16'd0);
        checkOutput("rstmid_cnt", stall_cnt_o, 16'd0);
        checkAllFwdZero("rstmid");
        reset_i = 1'b1;
        tick();
        applyBubble();
        checkOutput("rstmid_fers", {14'd0, fwd_e_rs_o}, 16'd0);
        checkOutput("rstmid_cnt2", stall_cnt_o, 16'd0);

        // Saturation: an instruction reading and rewriting $1 with lw timing stalls 2 of every 3 cycles
        doReset();
        applyStimulus(1'b1, 5'd1, 5'd0, 2'd0, 2'd3, 5'd1, 2'd2);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("sat_cnt6", stall_cnt_o, 16'd4);
        for (int i = 0; i < 98298; i++) tick();
        checkOutput("sat_full", stall_cnt_o, 16'hFFFF);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("sat_hold", stall_cnt_o, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
